// File: rtl/mux_8_1_pkg.sv
// mux_8_1_pkg: shared constants, state type and one-hot helper for the round-robin mux scheduler.
package mux_8_1_pkg;
   localparam int NUM_IN = 8;
   localparam int SEL_W = 3;
   typedef enum logic {IDLE, GRANT} sched_state_t;
   function automatic logic [NUM_IN-1:0] onehot8(input logic [SEL_W-1:0] idx);
      return NUM_IN'(1) << idx;
   endfunction
endpackage

// File: rtl/mux_rr_pick.sv
// mux_rr_pick: rotate-priority encoder, returns the first set request at or after ptr (mod 8).
module mux_rr_pick import mux_8_1_pkg::*; (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic              any,
   output logic [SEL_W-1:0]  idx
);
   logic [NUM_IN-1:0] rot;
   logic [SEL_W-1:0]  off;
   always_comb begin
      rot = NUM_IN'({req, req} >> ptr);
      off = '0;
      for (int i = NUM_IN-1; i >= 0; i--) off = rot[i] ? SEL_W'(i) : off;
      any = |req;
      idx = ptr + off;
   end
endmodule

// File: rtl/mux_8_1_rr_sched.sv
// mux_8_1_rr_sched: round-robin scheduler driving an 8:1 mux select with registered data/valid.
// Optional MUX_RR_LOCK_EN adds a lock[7:0] port that lets the winner hold past MAX_HOLD.
module mux_8_1_rr_sched import mux_8_1_pkg::*; #(
   parameter int NUM_IN   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_IN-1:0] req,
   input  logic [NUM_IN-1:0] d,
`ifdef MUX_RR_LOCK_EN
   input  logic [NUM_IN-1:0] lock,
`endif
   output logic [NUM_IN-1:0] grant,
   output logic [SEL_W-1:0]  sel,
   output logic              out_data,
   output logic              out_valid,
   output logic              busy
);
   localparam int HOLD_W = $clog2(MAX_HOLD+1);
   if (NUM_IN != 8) begin : g_bad_num
      $error("mux_8_1_rr_sched: NUM_IN must be 8");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
      $error("mux_8_1_rr_sched: MAX_HOLD must be 1..15");
   end
   sched_state_t      state, state_nx;
   logic [SEL_W-1:0]  ptr, ptr_nx, sel_nx, pick_idx;
   logic [HOLD_W-1:0] cnt, cnt_nx;
   logic              pick_any, at_max, rel, arb, take;
   mux_rr_pick u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
         sel   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         cnt   <= cnt_nx;
         sel   <= sel_nx;
      end
   end
   // ptr already sits one past the current winner, so re-arbitrating from it demotes the winner
   always_comb begin
      at_max = cnt == HOLD_W'(MAX_HOLD);
`ifdef MUX_RR_LOCK_EN
      rel = !req[sel] || (at_max && !(lock[sel] && req[sel]));
`else
      rel = !req[sel] || at_max;
`endif
      arb      = (state == IDLE) || rel;
      take     = arb && pick_any;
      state_nx = arb ? (pick_any ? GRANT : IDLE) : state;
      sel_nx   = take ? pick_idx : sel;
      ptr_nx   = take ? pick_idx + SEL_W'(1) : ptr;
      cnt_nx   = arb ? (pick_any ? HOLD_W'(1) : '0) : (at_max ? cnt : cnt + HOLD_W'(1));
   end
   always_comb begin
      grant = (state == GRANT) ? onehot8(sel) : '0;
      busy  = state == GRANT;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= 1'b0;
      end else begin
         out_valid <= |grant;
         out_data  <= (|grant) ? d[sel] : out_data;
      end
   end
endmodule

// File: doc/mux_8_1_rr_sched.md
Name: mux_8_1_rr_sched

Overview:
- Round-robin scheduler that shares the 8:1 single-bit mux datapath (D0..D7 -> out) among 8 requesters.
- Arbitrates `req[7:0]` and drives the mux select `sel[2:0]` (`sel[0]`=S0, `sel[1]`=S1, `sel[2]`=S2) with a one-hot grant.
- Registers the muxed data bit with a valid flag.
- Sits between requester logic and the fabric mux; drop-in sequencer for mux_8_1 in fabric tests.

Parameters:
- NUM_IN, 8, number of requesters / mux inputs; fixed at 8, elaborate-time error otherwise.
- MAX_HOLD, 4, maximum consecutive grant cycles per winner; legal range 1..15.
- HOLD_W, $clog2(MAX_HOLD+1), hold counter width; derived, not overridable.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request per input; level-sensitive.
- d  in  8  mux data inputs, d[i] = Di.
- grant  out  8  one-hot current winner, all-zero when idle.
- sel  out  3  mux select = index of winner; holds last value when idle.
- out_data  out  1  registered d[sel].
- out_valid  out  1  high one cycle after each granted cycle.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (async, immediate, any state): grant=0, sel=0, out_data=0, out_valid=0, busy=0, rr pointer ptr=0, hold cnt=0, state IDLE.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at a rising edge, pick the first set bit scanning ptr, ptr+1, ... mod 8.
  - Next state GRANT, grant=onehot(w), sel=w, cnt=1, ptr=w+1 mod 8 (wraps 7->0).
  - Arbitration latency is 1 cycle from req to grant.
- GRANT, winner w: release when `req[w]`=0, or when cnt==MAX_HOLD.
  - Release, at least one req set (w included): re-arbitrate the same edge from ptr, with no idle bubble. w gets lowest priority and is re-granted only if it is the sole requester; cnt restarts at 1.
  - Release, req==0: go to IDLE, grant=0, sel held.
  - No release: cnt++, grant/sel unchanged.
- Datapath:
  - Each edge: out_valid <= |grant; out_data <= d[sel] when |grant, else hold.
  - Data latency is 1 cycle after grant.
- grant is always one-hot or zero. sel changes only on an arbitration edge.
- A new req arriving during GRANT waits; it is never pre-empted in by itself.
- MAX_HOLD=1 gives pure per-cycle round robin.
- busy == (state==GRANT) == |grant.

Optional Feature:
- Macro: MUX_RR_LOCK_EN.
- Defined:
  - Extra input port `lock[7:0]`.
  - While `lock[w]` and `req[w]` are both high, the MAX_HOLD release is suppressed; cnt saturates at MAX_HOLD.
  - Release occurs only when `req[w]` drops, or `lock[w]` drops with cnt==MAX_HOLD.
  - lock on non-winners is ignored.
- Undefined: no lock port; MAX_HOLD is always enforced.

Decomposition:
- Package mux_8_1_pkg:
  - NUM_IN=8, SEL_W=3.
  - typedef enum logic {IDLE, GRANT} sched_state_t.
  - function onehot8(idx).
- Sub-module mux_rr_pick: combinational rotate-priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Instantiated once.

Test Plan:
- Async reset asserted mid-cycle at 3 ns with req=8'hFF -> all outputs 0 immediately. After release, first grant=8'h01, sel=0 one edge later.
- req=8'h01 held, MAX_HOLD=4 -> grant=8'h01 continuous. cnt wraps 1,2,3,4,1; out_valid stays 1.
- req=8'hFF, MAX_HOLD=4 -> grant sequence 01,02,04,...,80,01, each held 4 cycles; sel 0..7 then 0.
- d=8'b01010101, req=8'b00001100 -> sel=2, out_data=1 for 4 cycles; then sel=3, out_data=0, each one cycle after grant.
- req=8'h08; drop req[3] after 2 grant cycles -> grant=0 on the next edge, state IDLE. out_valid falls one cycle later; sel stays 3.
- MUX_RR_LOCK_EN, req=8'h21, lock=8'h01 -> grant=8'h01 held 10 cycles. Drop lock -> grant moves to 8'h20 on the next edge.
